enemigo_avance: RTL and testbench
=================================

Name: enemigo_avance

Overview:
- Downstream consumer of the enemy divided clock: turns the slow square wave into movement of one enemy car down the road grid.
- Synchronises the slow clock into the system domain and detects its rising edges ("ticks").
- Spawns the car in a pseudo-random lane, advances it one row per tick, and flags a collision with the player car.
- Outputs feed the display/renderer and the score/game-over logic.

Parameters:
- ROWS, 16, number of road rows; row 0 is the top, row ROWS-1 is the bottom; range 2..16.
- PLAYER_ROW, 14, row occupied by the player car; must satisfy 1 <= PLAYER_ROW <= ROWS-1.
- SPAWN_DELAY, 3, ticks spent hidden before each spawn; must be at least 1.
- HIT_TICKS, 4, ticks the crashed car stays displayed after a collision; must be at least 1.
- LFSR_SEED, 8'hA5, initial value of the lane generator; must be non-zero.

Ports:
- clock_in, input, 1, system clock; all logic is on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- enemy_clk, input, 1, divided enemy clock (about 50% duty); asynchronous to clock_in.
- enable, input, 1, game running; when low, ticks are ignored.
- player_lane, input, 2, current player lane 0..3.
- enemy_row, output, 4, current enemy row.
- enemy_lane, output, 2, current enemy lane.
- enemy_active, output, 1, enemy visible on screen.
- collision, output, 1, one-cycle pulse on a hit.
- pass_count, output, 8, number of enemies that left the bottom without a hit; saturates at 255.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-move):
  - enemy_row=0, enemy_lane=0, enemy_active=0, collision=0, pass_count=0.
  - state=S_WAIT, wait_cnt=0, lfsr=LFSR_SEED.
  - Synchroniser flops and the edge-detect flop reset to 0. If enemy_clk is already high at reset release, that produces exactly one tick.
- Tick generation:
  - Two-flop synchroniser on enemy_clk, then a rising-edge detect.
  - The tick is a single-cycle pulse. It is acted on at the 3rd clock_in rising edge after the enemy_clk rise (worst case 4, depending on sampling).
  - Falling edges of enemy_clk produce nothing.
- Lane generator:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, shifts every clock_in cycle regardless of enable.
  - Never reaches 0.
  - At spawn, enemy_lane <= lfsr[1:0] as sampled in the spawn cycle.
- Enable: all state, counters and outputs are frozen while enable=0, and collision stays 0. A tick that occurs while enable=0 is discarded, not queued.
- FSM (every transition happens only on a tick with enable=1):
  - S_WAIT:
    - enemy_active=0.
    - If wait_cnt < SPAWN_DELAY-1: wait_cnt++.
    - Otherwise: wait_cnt<=0, enemy_row<=0, enemy_lane<=lfsr[1:0], enemy_active<=1, go to S_MOVE.
  - S_MOVE, checked in this priority order:
    - (a) enemy_row==PLAYER_ROW-1 and enemy_lane==player_lane (player_lane sampled in the tick cycle): enemy_row<=PLAYER_ROW, collision<=1 for exactly one cycle, wait_cnt<=0, go to S_HIT.
    - (b) enemy_row==ROWS-1: enemy_active<=0, pass_count<=pass_count+1 (held at 255 once reached), go to S_WAIT.
    - (c) Otherwise: enemy_row<=enemy_row+1.
  - S_HIT:
    - Car stays visible at PLAYER_ROW in its lane.
    - If wait_cnt < HIT_TICKS-1: wait_cnt++.
    - Otherwise: wait_cnt<=0, enemy_active<=0, go to S_WAIT. pass_count is unchanged.
- Collision rule:
  - Evaluated only on the row step into PLAYER_ROW.
  - A lane change by the player while the enemy sits at PLAYER_ROW or below does not cause a hit.
- The enemy never wraps from row ROWS-1 back to 0 while visible. It always passes through S_WAIT first.
- Unreachable FSM encodings return to S_WAIT on the next cycle.

Test Plan:
1. Reset release with enemy_clk=0, enable=1, enemy_clk toggled every 20 cycles -> enemy_active rises on the 3rd tick; enemy_row=0; enemy_lane matches the bench LFSR model.
2. Full pass with player_lane forced different from enemy_lane -> enemy_row steps 0..15 (one step per tick); on the next tick enemy_active=0 and pass_count=1; collision never asserts.
3. player_lane tracks enemy_lane -> on the tick from row 13 to 14, collision is high for exactly 1 cycle; enemy stays at row 14 for 4 ticks, then hides; pass_count is unchanged.
4. enable=0 for 5 ticks mid-move at row 6 -> enemy_row stays 6; after enable=1 the next tick gives row 7.
5. Preload pass_count to 255 via repeated passes -> a further pass keeps it at 255.
6. reset_n pulsed low mid-move at row 9, asynchronous to clock_in -> all outputs go to 0 immediately; after release the spawn again takes 3 ticks.

Source files
------------

// File: rtl/enemigo_avance.sv
// Enemy car mover: turns the slow enemy clock into per-tick row steps, lane spawns and player hits.
// Latency: an enemy_clk rise acts on the 3rd clock_in edge (4 worst case); outputs are registered.
// No flow control: ticks arriving while enable is low are dropped, and all state holds meanwhile.
module enemigo_avance #(
    parameter int         ROWS        = 16,
    parameter int         PLAYER_ROW  = 14,
    parameter int         SPAWN_DELAY = 3,
    parameter int         HIT_TICKS   = 4,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       enemy_clk,
    input  logic       enable,
    input  logic [1:0] player_lane,
    output logic [3:0] enemy_row,
    output logic [1:0] enemy_lane,
    output logic       enemy_active,
    output logic       collision,
    output logic [7:0] pass_count
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_MOVE = 2'd1,
        S_HIT  = 2'd2
    } state_t;

    // Row and tick-count landmarks, pre-sized to the register widths.
    localparam logic [3:0] ROW_LAST   = 4'(ROWS - 1);
    localparam logic [3:0] HIT_ROW    = 4'(PLAYER_ROW);
    localparam logic [3:0] PRE_HIT    = 4'(PLAYER_ROW - 1);
    localparam logic [7:0] SPAWN_LAST = 8'(SPAWN_DELAY - 1);
    localparam logic [7:0] HIT_LAST   = 8'(HIT_TICKS - 1);
    localparam logic [7:0] PASS_MAX   = 8'hFF;

    // Tick generation
    logic sync1;
    logic sync2;
    logic clk_prev;
    logic tick;
    logic step;

    // Lane generator
    logic [7:0] lfsr;
    logic       lfsr_fb;

    // FSM state and next-state values
    state_t     state;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic [7:0] wait_d;
    logic [3:0] row_d;
    logic [1:0] lane_d;
    logic       active_d;
    logic       coll_d;
    logic [7:0] pass_d;

    // Two-flop synchroniser on enemy_clk plus the history flop for rising-edge detection.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            clk_prev <= 1'b0;
        end else begin
            sync1    <= enemy_clk;
            sync2    <= sync1;
            clk_prev <= sync2;
        end
    end

    // The history flop advances even when disabled, so a tick seen while disabled is consumed, not queued.
    assign tick = sync2 & ~clk_prev;
    assign step = tick & enable;

    // Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4); a non-zero seed keeps it off the all-zero lockup state.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // Next-state logic: all movement happens only on an enabled tick; otherwise everything holds.
    always_comb begin
        state_d  = state;
        wait_d   = wait_cnt;
        row_d    = enemy_row;
        lane_d   = enemy_lane;
        active_d = enemy_active;
        pass_d   = pass_count;
        coll_d   = 1'b0;

        case (state)
            S_WAIT: begin
                if (step) begin
                    if (wait_cnt < SPAWN_LAST) begin
                        wait_d = wait_cnt + 8'd1;
                    end else begin
                        wait_d   = 8'd0;
                        row_d    = 4'd0;
                        lane_d   = lfsr[1:0];
                        active_d = 1'b1;
                        state_d  = S_MOVE;
                    end
                end
            end

            S_MOVE: begin
                if (step) begin
                    // A hit can only be scored on the step into the player's row.
                    if ((enemy_row == PRE_HIT) && (enemy_lane == player_lane)) begin
                        row_d   = HIT_ROW;
                        coll_d  = 1'b1;
                        wait_d  = 8'd0;
                        state_d = S_HIT;
                    end else if (enemy_row == ROW_LAST) begin
                        active_d = 1'b0;
                        if (pass_count != PASS_MAX) begin
                            pass_d = pass_count + 8'd1;
                        end
                        state_d = S_WAIT;
                    end else begin
                        row_d = enemy_row + 4'd1;
                    end
                end
            end

            S_HIT: begin
                // Crashed car stays parked at the player's row while the hit is shown.
                if (step) begin
                    if (wait_cnt < HIT_LAST) begin
                        wait_d = wait_cnt + 8'd1;
                    end else begin
                        wait_d   = 8'd0;
                        active_d = 1'b0;
                        state_d  = S_WAIT;
                    end
                end
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_WAIT;
            wait_cnt     <= 8'd0;
            enemy_row    <= 4'd0;
            enemy_lane   <= 2'd0;
            enemy_active <= 1'b0;
            collision    <= 1'b0;
            pass_count   <= 8'd0;
        end else begin
            state        <= state_d;
            wait_cnt     <= wait_d;
            enemy_row    <= row_d;
            enemy_lane   <= lane_d;
            enemy_active <= active_d;
            collision    <= coll_d;
            pass_count   <= pass_d;
        end
    end

endmodule

// File: tb/tb_enemigo_avance.sv
// Directed bench for enemigo_avance: spawn timing, full pass, hit, enable freeze, saturation, async reset.
// Each tick is a hand-driven enemy_clk pulse; outputs are sampled on clock_in falling edges.
// Lane expectations come from an independent LFSR model stepped on the same clock and reset.
module tb_enemigo_avance;

    logic       clock_in    = 1'b0;
    logic       reset_n     = 1'b0;
    logic       enemy_clk   = 1'b0;
    logic       enable      = 1'b0;
    logic [1:0] player_lane = 2'd0;
    logic [3:0] enemy_row;
    logic [1:0] enemy_lane;
    logic       enemy_active;
    logic       collision;
    logic [7:0] pass_count;

    int n_cmp    = 0;
    int n_err    = 0;
    int coll_cnt = 0;

    logic [7:0] m;
    logic [1:0] cand_lane = 2'd0;
    logic [1:0] exp_lane  = 2'd0;

    always #5 clock_in = ~clock_in;

    enemigo_avance dut (
        .clock_in     (clock_in),
        .reset_n      (reset_n),
        .enemy_clk    (enemy_clk),
        .enable       (enable),
        .player_lane  (player_lane),
        .enemy_row    (enemy_row),
        .enemy_lane   (enemy_lane),
        .enemy_active (enemy_active),
        .collision    (collision),
        .pass_count   (pass_count)
    );

    // Reference lane generator: x^8+x^6+x^5+x^4 Fibonacci LFSR seeded with A5.
    always @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) m <= 8'hA5;
        else          m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end

    // One enemy_clk period; the model value feeding the 3rd edge after the rise is kept as cand_lane.
    task automatic do_tick(input int half);
        enemy_clk = 1'b1;
        for (int i = 0; i < half; i++) begin
            @(negedge clock_in);
            if (collision) coll_cnt++;
            if (i == 1) cand_lane = m[1:0];
        end
        enemy_clk = 1'b0;
        for (int i = 0; i < half; i++) begin
            @(negedge clock_in);
            if (collision) coll_cnt++;
        end
    endtask

    // Hidden wait, spawn, then 16 ticks off the enemy's lane to leave the bottom.
    task automatic do_pass(input int half);
        do_tick(half);
        do_tick(half);
        do_tick(half);
        player_lane = cand_lane ^ 2'd1;
        for (int k = 0; k < 16; k++) do_tick(half);
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        enable    = 1'b1;
        enemy_clk = 1'b0;
        repeat (3) @(negedge clock_in);
        n_cmp++; if (enemy_row !== 4'd0) begin n_err++; $display("FAIL reset_row got %0d want 0", enemy_row); end
        n_cmp++; if (enemy_lane !== 2'd0) begin n_err++; $display("FAIL reset_lane got %0d want 0", enemy_lane); end
        n_cmp++; if (enemy_active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b want 0", enemy_active); end
        n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL reset_collision got %b want 0", collision); end
        n_cmp++; if (pass_count !== 8'd0) begin n_err++; $display("FAIL reset_pass got %0d want 0", pass_count); end
        reset_n = 1'b1;
        do_tick(20);
        n_cmp++; if (enemy_active !== 1'b0) begin n_err++; $display("FAIL spawn_tick1_active got %b want 0", enemy_active); end
        do_tick(20);
        n_cmp++; if (enemy_active !== 1'b0) begin n_err++; $display("FAIL spawn_tick2_active got %b want 0", enemy_active); end
        do_tick(20);
        exp_lane = cand_lane;
        n_cmp++; if (enemy_active !== 1'b1) begin n_err++; $display("FAIL spawn_tick3_active got %b want 1", enemy_active); end
        n_cmp++; if (enemy_row !== 4'd0) begin n_err++; $display("FAIL spawn_row got %0d want 0", enemy_row); end
        n_cmp++; if (enemy_lane !== exp_lane) begin n_err++; $display("FAIL spawn_lane got %0d want %0d", enemy_lane, exp_lane); end
    endtask

    task automatic test_full_pass;
        player_lane = exp_lane ^ 2'd1;
        coll_cnt    = 0;
        for (int k = 1; k <= 15; k++) begin
            do_tick(20);
            n_cmp++; if (enemy_row !== 4'(k)) begin n_err++; $display("FAIL pass_row got %0d want %0d", enemy_row, k); end
        end
        n_cmp++; if (enemy_active !== 1'b1) begin n_err++; $display("FAIL pass_bottom_active got %b want 1", enemy_active); end
        do_tick(20);
        n_cmp++; if (enemy_active !== 1'b0) begin n_err++; $display("FAIL pass_exit_active got %b want 0", enemy_active); end
        n_cmp++; if (pass_count !== 8'd1) begin n_err++; $display("FAIL pass_count got %0d want 1", pass_count); end
        n_cmp++; if (coll_cnt !== 0) begin n_err++; $display("FAIL pass_no_collision got %0d want 0", coll_cnt); end
    endtask

    task automatic test_collision;
        do_tick(20);
        do_tick(20);
        do_tick(20);
        exp_lane = cand_lane;
        n_cmp++; if (enemy_lane !== exp_lane) begin n_err++; $display("FAIL hit_spawn_lane got %0d want %0d", enemy_lane, exp_lane); end
        player_lane = exp_lane;
        coll_cnt    = 0;
        for (int k = 1; k <= 13; k++) do_tick(20);
        n_cmp++; if (enemy_row !== 4'd13) begin n_err++; $display("FAIL hit_pre_row got %0d want 13", enemy_row); end
        n_cmp++; if (coll_cnt !== 0) begin n_err++; $display("FAIL hit_early_collision got %0d want 0", coll_cnt); end
        do_tick(20);
        n_cmp++; if (coll_cnt !== 1) begin n_err++; $display("FAIL hit_pulse_cycles got %0d want 1", coll_cnt); end
        n_cmp++; if (enemy_row !== 4'd14) begin n_err++; $display("FAIL hit_row got %0d want 14", enemy_row); end
        player_lane = exp_lane ^ 2'd2;
        for (int k = 1; k <= 3; k++) begin
            do_tick(20);
            n_cmp++; if (enemy_active !== 1'b1 || enemy_row !== 4'd14) begin
                n_err++; $display("FAIL hit_hold got active=%b row=%0d want active=1 row=14", enemy_active, enemy_row);
            end
        end
        do_tick(20);
        n_cmp++; if (enemy_active !== 1'b0) begin n_err++; $display("FAIL hit_hide_active got %b want 0", enemy_active); end
        n_cmp++; if (pass_count !== 8'd1) begin n_err++; $display("FAIL hit_pass_count got %0d want 1", pass_count); end
        n_cmp++; if (coll_cnt !== 1) begin n_err++; $display("FAIL hit_total_pulses got %0d want 1", coll_cnt); end
    endtask

    task automatic test_enable_freeze;
        do_tick(20);
        do_tick(20);
        do_tick(20);
        player_lane = cand_lane ^ 2'd1;
        coll_cnt    = 0;
        for (int k = 1; k <= 6; k++) do_tick(20);
        n_cmp++; if (enemy_row !== 4'd6) begin n_err++; $display("FAIL freeze_start_row got %0d want 6", enemy_row); end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) do_tick(20);
        n_cmp++; if (enemy_row !== 4'd6) begin n_err++; $display("FAIL freeze_row got %0d want 6", enemy_row); end
        n_cmp++; if (enemy_active !== 1'b1) begin n_err++; $display("FAIL freeze_active got %b want 1", enemy_active); end
        enable = 1'b1;
        do_tick(20);
        n_cmp++; if (enemy_row !== 4'd7) begin n_err++; $display("FAIL unfreeze_row got %0d want 7", enemy_row); end
        for (int k = 8; k <= 15; k++) do_tick(20);
        n_cmp++; if (enemy_row !== 4'd15) begin n_err++; $display("FAIL freeze_bottom_row got %0d want 15", enemy_row); end
        do_tick(20);
        n_cmp++; if (pass_count !== 8'd2) begin n_err++; $display("FAIL freeze_pass_count got %0d want 2", pass_count); end
        n_cmp++; if (coll_cnt !== 0) begin n_err++; $display("FAIL freeze_collision got %0d want 0", coll_cnt); end
    endtask

    task automatic test_saturation;
        for (int p = 0; p < 252; p++) do_pass(4);
        n_cmp++; if (pass_count !== 8'd254) begin n_err++; $display("FAIL sat_254 got %0d want 254", pass_count); end
        do_pass(4);
        n_cmp++; if (pass_count !== 8'd255) begin n_err++; $display("FAIL sat_255 got %0d want 255", pass_count); end
        do_pass(4);
        n_cmp++; if (pass_count !== 8'd255) begin n_err++; $display("FAIL sat_hold got %0d want 255", pass_count); end
    endtask

    task automatic test_async_reset;
        do_tick(20);
        do_tick(20);
        do_tick(20);
        player_lane = cand_lane ^ 2'd1;
        for (int k = 1; k <= 9; k++) do_tick(20);
        n_cmp++; if (enemy_row !== 4'd9) begin n_err++; $display("FAIL areset_pre_row got %0d want 9", enemy_row); end
        @(posedge clock_in);
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (enemy_row !== 4'd0) begin n_err++; $display("FAIL areset_row got %0d want 0", enemy_row); end
        n_cmp++; if (enemy_lane !== 2'd0) begin n_err++; $display("FAIL areset_lane got %0d want 0", enemy_lane); end
        n_cmp++; if (enemy_active !== 1'b0) begin n_err++; $display("FAIL areset_active got %b want 0", enemy_active); end
        n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL areset_collision got %b want 0", collision); end
        n_cmp++; if (pass_count !== 8'd0) begin n_err++; $display("FAIL areset_pass got %0d want 0", pass_count); end
        repeat (2) @(negedge clock_in);
        reset_n = 1'b1;
        do_tick(20);
        n_cmp++; if (enemy_active !== 1'b0) begin n_err++; $display("FAIL respawn_tick1_active got %b want 0", enemy_active); end
        do_tick(20);
        n_cmp++; if (enemy_active !== 1'b0) begin n_err++; $display("FAIL respawn_tick2_active got %b want 0", enemy_active); end
        do_tick(20);
        n_cmp++; if (enemy_active !== 1'b1) begin n_err++; $display("FAIL respawn_tick3_active got %b want 1", enemy_active); end
        n_cmp++; if (enemy_row !== 4'd0) begin n_err++; $display("FAIL respawn_row got %0d want 0", enemy_row); end
        n_cmp++; if (enemy_lane !== cand_lane) begin n_err++; $display("FAIL respawn_lane got %0d want %0d", enemy_lane, cand_lane); end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_collision();
        test_enable_freeze();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
